register_file_n: RTL

Parametrised multi-register storage block for the 16-bit processor datapath. It generalises the single enable-gated register into a bank of DEPTH registers of width N. The bank has one synchronous write port, two independent read ports and a per-register valid flag. It sits between the control unit and the ALU and replaces the discrete general-purpose register instances.

---
 rtl/register_file_n.sv | 97 +++++++++
 1 files changed

// File: rtl/register_file_n.sv
// register_file_n: DEPTH x N register bank, one synchronous write port, two combinational read ports, per-register valid flags.
//
// Ports:
//   clk       in  1   rising-edge clock
//   rst_n     in  1   asynchronous active-low reset (all data and valid bits to 0)
//   clr       in  1   synchronous clear-all; wins over r_in
//   r_in      in  1   write enable
//   w_addr    in  AW  write address (writes to addresses >= DEPTH are ignored)
//   data_in   in  N   write data
//   ra_addr   in  AW  read port A address
//   rb_addr   in  AW  read port B address
//   qa, qb    out N   read data (0 for addresses >= DEPTH)
//   qa_valid  out 1   addressed register written since last reset/clear
//   qb_valid  out 1   same, for port B
//
// Build option: define REGFILE_BYPASS_EN to forward data_in to a read port that
// addresses the register being written in the same cycle.
module register_file_n #(
    parameter int N = 16,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          r_in,
    input  logic [AW-1:0] w_addr,
    input  logic [N-1:0]  data_in,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    output logic [N-1:0]  qa,
    output logic [N-1:0]  qb,
    output logic          qa_valid,
    output logic          qb_valid
);
    logic [N-1:0]     data_q  [DEPTH];
    logic [N-1:0]     data_d  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic             wr_ok;

    // rst_n is included so the bypass path is also silenced during reset
    assign wr_ok = rst_n && r_in && !clr && (int'(w_addr) < DEPTH);

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (clr) begin
                data_d[i]  = '0;
                valid_d[i] = 1'b0;
            end else if (wr_ok && w_addr == AW'(i)) begin
                data_d[i]  = data_in;
                valid_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Decoded mux so out-of-range addresses naturally read back as 0/invalid
    always_comb begin
        qa       = '0;
        qb       = '0;
        qa_valid = 1'b0;
        qb_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ra_addr == AW'(i)) begin
                qa       = data_q[i];
                qa_valid = valid_q[i];
            end
            if (rb_addr == AW'(i)) begin
                qb       = data_q[i];
                qb_valid = valid_q[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && ra_addr == w_addr) begin
            qa       = data_in;
            qa_valid = 1'b1;
        end
        if (wr_ok && rb_addr == w_addr) begin
            qb       = data_in;
            qb_valid = 1'b1;
        end
`else
`endif
    end
endmodule
